// File: rtl/mips_arb_pkg.sv
// Shared types and sizes for the four-way memory port arbiter.
// Imported by rr_pick4 and mem_port_arbiter.
package mips_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Requester index k positions after p, wrapping at NUM_REQ.
  function automatic logic [SEL_W-1:0] ptr_add(
    input logic [SEL_W-1:0] p,
    input logic [SEL_W-1:0] k
  );
    return p + k;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin pick over four masked requests.
// Scan starts just after the last owner and wraps.
module rr_pick4
  import mips_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr_add(last_i, SEL_W'(k));
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared 32-bit memory port; drives mux select.
// Define ARB_TIMEOUT_EN to force-release a BUSY owner after MAX_HOLD cycles.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mem_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               mem_valid,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last_q;
  logic               valid_q;
  logic [NUM_REQ-1:0] done_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  // A requester still sees its done pulse while req is high; skip it.
  assign elig = req & ~done_q;

  rr_pick4 u_pick (
    .req_i   (elig),
    .last_i  (last_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       tout_q;
  logic       hold_hit;

  assign hold_d   = hold_q + 8'd1;
  assign hold_hit = (hold_d == HOLD_LIM);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      valid_q <= 1'b0;
      done_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef ARB_TIMEOUT_EN
      tout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= BUSY;
            grant_q <= pick_gnt;
            sel_q   <= pick_idx;
            last_q  <= pick_idx;
            valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        BUSY: begin
          // sel_q is left alone on release so the mux does not glitch.
          if (mem_ready) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            done_q  <= grant_q;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            done_q  <= grant_q;
            tout_q  <= 1'b1;
          end else begin
            hold_q  <= hold_d;
`endif
          end
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign mem_valid = valid_q;
  assign done      = done_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = tout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
